// File: rtl/vga_timing_driver.sv
// VGA 640x480@60 timing driver: pixel-rate divider, scan counters with phase FSMs,
// and a registered, blanked RGB/sync output stage one pixel behind the counters.
module vga_timing_driver #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned HPIXELS = 640,
    parameter int unsigned HFP     = 16,
    parameter int unsigned HSYNC   = 96,
    parameter int unsigned HBP     = 48,
    parameter int unsigned VPIXELS = 480,
    parameter int unsigned VFP     = 10,
    parameter int unsigned VSYNC   = 2,
    parameter int unsigned VBP     = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [11:0] pixelColor,
    output logic [9:0]  horizCount,
    output logic [9:0]  vertCount,
    output logic        pixelTick,
    output logic        displayActive,
    output logic        frameStart,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  vgaRed,
    output logic [3:0]  vgaGreen,
    output logic [3:0]  vgaBlue
);

    localparam int unsigned CW     = 10;
    localparam int unsigned HTOTAL = HPIXELS + HFP + HSYNC + HBP;
    localparam int unsigned VTOTAL = VPIXELS + VFP + VSYNC + VBP;
    localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [CW-1:0] H_ACT_END = CW'(HPIXELS - 1);
    localparam logic [CW-1:0] H_FP_END  = CW'(HPIXELS + HFP - 1);
    localparam logic [CW-1:0] H_SY_END  = CW'(HPIXELS + HFP + HSYNC - 1);
    localparam logic [CW-1:0] H_END     = CW'(HTOTAL - 1);
    localparam logic [CW-1:0] V_ACT_END = CW'(VPIXELS - 1);
    localparam logic [CW-1:0] V_FP_END  = CW'(VPIXELS + VFP - 1);
    localparam logic [CW-1:0] V_SY_END  = CW'(VPIXELS + VFP + VSYNC - 1);
    localparam logic [CW-1:0] V_END     = CW'(VTOTAL - 1);

    localparam logic [1:0] H_ACTIVE = 2'd0;
    localparam logic [1:0] H_FRONT  = 2'd1;
    localparam logic [1:0] H_SYNC   = 2'd2;
    localparam logic [1:0] H_BACK   = 2'd3;
    localparam logic [1:0] V_ACTIVE = 2'd0;
    localparam logic [1:0] V_FRONT  = 2'd1;
    localparam logic [1:0] V_SYNC   = 2'd2;
    localparam logic [1:0] V_BACK   = 2'd3;

    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_h_state;
    logic [1:0]       r_v_state;
    logic [CW-1:0]    r_h_cnt;
    logic [CW-1:0]    r_v_cnt;
    logic             r_tick;
    logic             r_frame_start;
    logic             r_hsync;
    logic             r_vsync;
    logic [11:0]      r_rgb;

    logic             w_tick;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic             w_active;
    logic [1:0]       w_h_state_nxt;
    logic [1:0]       w_v_state_nxt;
    logic [CW-1:0]    w_h_cnt_nxt;
    logic [CW-1:0]    w_v_cnt_nxt;

    assign w_tick   = enable && (r_div == DIV_LAST);
    assign w_h_wrap = (r_h_cnt == H_END);
    assign w_v_wrap = (r_v_cnt == V_END);
    assign w_active = (r_h_state == H_ACTIVE) && (r_v_state == V_ACTIVE);

    // Next counters and phases; the vertical side only moves on the last pixel of a line.
    always_comb begin
        w_h_state_nxt = r_h_state;
        w_v_state_nxt = r_v_state;
        w_h_cnt_nxt   = r_h_cnt;
        w_v_cnt_nxt   = r_v_cnt;
        if (w_tick) begin
            w_h_cnt_nxt = w_h_wrap ? '0 : r_h_cnt + 1'b1;
            case (r_h_state)
                H_ACTIVE: if (r_h_cnt == H_ACT_END) w_h_state_nxt = H_FRONT;
                H_FRONT:  if (r_h_cnt == H_FP_END)  w_h_state_nxt = H_SYNC;
                H_SYNC:   if (r_h_cnt == H_SY_END)  w_h_state_nxt = H_BACK;
                H_BACK:   if (w_h_wrap)             w_h_state_nxt = H_ACTIVE;
            endcase
            if (w_h_wrap) begin
                w_v_cnt_nxt = w_v_wrap ? '0 : r_v_cnt + 1'b1;
                case (r_v_state)
                    V_ACTIVE: if (r_v_cnt == V_ACT_END) w_v_state_nxt = V_FRONT;
                    V_FRONT:  if (r_v_cnt == V_FP_END)  w_v_state_nxt = V_SYNC;
                    V_SYNC:   if (r_v_cnt == V_SY_END)  w_v_state_nxt = V_BACK;
                    V_BACK:   if (w_v_wrap)             w_v_state_nxt = V_ACTIVE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div     <= '0;
            r_h_state <= H_ACTIVE;
            r_v_state <= V_ACTIVE;
            r_h_cnt   <= '0;
            r_v_cnt   <= '0;
        end else begin
            r_div     <= (!enable || w_tick) ? '0 : r_div + 1'b1;
            r_h_state <= w_h_state_nxt;
            r_v_state <= w_v_state_nxt;
            r_h_cnt   <= w_h_cnt_nxt;
            r_v_cnt   <= w_v_cnt_nxt;
        end
    end

    // Output stage samples the pre-advance counts, so pins trail the counters by one pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick        <= 1'b0;
            r_frame_start <= 1'b0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_rgb         <= '0;
        end else if (!enable) begin
            r_tick        <= 1'b0;
            r_frame_start <= 1'b0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_rgb         <= '0;
        end else begin
            r_tick        <= w_tick;
            r_frame_start <= w_tick && w_h_wrap && w_v_wrap;
            if (w_tick) begin
                r_rgb   <= w_active ? pixelColor : '0;
                r_hsync <= (r_h_state != H_SYNC);
                r_vsync <= (r_v_state != V_SYNC);
            end
        end
    end

    assign horizCount    = r_h_cnt;
    assign vertCount     = r_v_cnt;
    assign pixelTick     = r_tick;
    assign frameStart    = r_frame_start;
    assign displayActive = w_active;
    assign hsync         = r_hsync;
    assign vsync         = r_vsync;
    assign vgaRed        = r_rgb[11:8];
    assign vgaGreen      = r_rgb[7:4];
    assign vgaBlue       = r_rgb[3:0];

endmodule

// File: tb/tb_vga_timing_driver.sv
// Bench: a reduced-geometry instance under a queued scoreboard with random stimulus,
// plus a full 640x480 instance checked tick by tick over the first lines.
module tb_vga_timing_driver;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned S_HP = 8, S_HFP = 2, S_HS = 3, S_HBP = 2;
    localparam int unsigned S_VP = 6, S_VFP = 2, S_VS = 2, S_VBP = 3;
    localparam int S_HT = S_HP + S_HFP + S_HS + S_HBP;
    localparam int S_VT = S_VP + S_VFP + S_VS + S_VBP;
    localparam int FULL_CLKS = 3 * 3200 + 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        s_rst_n, s_en, s_tick, s_act, s_fs, s_hs, s_vs;
    logic [11:0] s_col;
    logic [9:0]  s_h, s_v;
    logic [3:0]  s_r, s_g, s_b;

    logic        f_rst_n, f_en, f_tick, f_act, f_fs, f_hs, f_vs;
    logic [11:0] f_col;
    logic [9:0]  f_h, f_v;
    logic [3:0]  f_r, f_g, f_b;

    vga_timing_driver #(
        .CLK_DIV(CLK_DIV), .HPIXELS(S_HP), .HFP(S_HFP), .HSYNC(S_HS), .HBP(S_HBP),
        .VPIXELS(S_VP), .VFP(S_VFP), .VSYNC(S_VS), .VBP(S_VBP)
    ) u_dut (
        .clk(clk), .rst_n(s_rst_n), .enable(s_en), .pixelColor(s_col),
        .horizCount(s_h), .vertCount(s_v), .pixelTick(s_tick), .displayActive(s_act),
        .frameStart(s_fs), .hsync(s_hs), .vsync(s_vs),
        .vgaRed(s_r), .vgaGreen(s_g), .vgaBlue(s_b)
    );

    vga_timing_driver u_full (
        .clk(clk), .rst_n(f_rst_n), .enable(f_en), .pixelColor(f_col),
        .horizCount(f_h), .vertCount(f_v), .pixelTick(f_tick), .displayActive(f_act),
        .frameStart(f_fs), .hsync(f_hs), .vsync(f_vs),
        .vgaRed(f_r), .vgaGreen(f_g), .vgaBlue(f_b)
    );

    typedef struct {
        int          cyc;
        logic        tick;
        int          h;
        int          v;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        fs;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   full_done = 1'b0;

    // Reference model: enabled-clock run length and linear raster position
    int m_run = 0;
    int m_pos = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int m_h();
        return m_pos % S_HT;
    endfunction

    function automatic int m_v();
        return m_pos / S_HT;
    endfunction

    // Apply one clock of stimulus and predict the DUT response at the next rising edge.
    task automatic drive_cycle(input logic e, input logic [11:0] c);
        exp_t x;
        int   h;
        int   v;
        @(negedge clk);
        s_en  = e;
        s_col = c;
        h = m_h();
        v = m_v();
        x.cyc = cyc + 1;
        if (!e) begin
            m_run  = 0;
            x.tick = 1'b0; x.h = h; x.v = v; x.rgb = 12'h000;
            x.hs = 1'b1; x.vs = 1'b1; x.fs = 1'b0;
            sb_q.push_back(x);
        end else begin
            m_run++;
            if (m_run % CLK_DIV == 0) begin
                x.tick = 1'b1;
                x.rgb  = (h < S_HP && v < S_VP) ? c : 12'h000;
                x.hs   = !(h >= S_HP + S_HFP && h < S_HP + S_HFP + S_HS);
                x.vs   = !(v >= S_VP + S_VFP && v < S_VP + S_VFP + S_VS);
                m_pos  = (m_pos + 1) % (S_HT * S_VT);
                x.h    = m_h();
                x.v    = m_v();
                x.fs   = (m_pos == 0);
                sb_q.push_back(x);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_h"}, s_h, 0);
        chk({tag, "_v"}, s_v, 0);
        chk({tag, "_tick"}, s_tick, 0);
        chk({tag, "_fs"}, s_fs, 0);
        chk({tag, "_hsync"}, s_hs, 1);
        chk({tag, "_vsync"}, s_vs, 1);
        chk({tag, "_rgb"}, {s_r, s_g, s_b}, 0);
    endtask

    task automatic run_to(input int h, input int vmin, input string tag);
        int n;
        n = 0;
        while (!(m_h() == h && m_v() >= vmin) && n < 2000) begin
            drive_cycle(1'b1, 12'($urandom));
            n++;
        end
        if (n >= 2000) begin
            errors++;
            checks++;
            $display("FAIL %s: position (%0d,>=%0d) not reached within 2000 clks", tag, h, vmin);
        end
    endtask

    // Scoreboard monitor for the reduced instance
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                x = sb_q.pop_front();
                errors++;
                checks++;
                $display("FAIL missed_event: expected event at cycle %0d never checked (now %0d)", x.cyc, cyc);
            end
            if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
                x = sb_q.pop_front();
                chk("tick", s_tick, x.tick);
                chk("hcount", s_h, x.h);
                chk("vcount", s_v, x.v);
                chk("rgb", {s_r, s_g, s_b}, x.rgb);
                chk("hsync", s_hs, x.hs);
                chk("vsync", s_vs, x.vs);
                chk("frame_start", s_fs, x.fs);
            end else begin
                chk("spurious_tick", s_tick, 0);
                chk("spurious_fs", s_fs, 0);
            end
            chk("display_active", s_act, (s_h < S_HP && s_v < S_VP) ? 1 : 0);
        end
    end

    // Full-geometry checker: tick n must land on clock 4n with the counts of pixel n
    initial begin
        int n, k, low_ticks, ph, pv;
        bit seen_fall, seen_line;
        n = 0; low_ticks = 0; seen_fall = 0; seen_line = 0;
        wait (f_rst_n === 1'b1);
        for (k = 1; k <= FULL_CLKS; k++) begin
            @(posedge clk);
            #1;
            if (f_tick) begin
                n++;
                ph = (n - 1) % 800;
                pv = (n - 1) / 800;
                chk("full_tick_time", k, 4 * n);
                chk("full_hcount", f_h, n % 800);
                chk("full_vcount", f_v, n / 800);
                chk("full_rgb", {f_r, f_g, f_b}, (ph < 640 && pv < 480) ? 12'hF3A : 12'h000);
                chk("full_hsync", f_hs, (ph >= 656 && ph < 752) ? 0 : 1);
                chk("full_vsync", f_vs, 1);
                chk("full_fs", f_fs, 0);
                if (n <= 800 && !f_hs) low_ticks++;
                if (!f_hs && !seen_fall) begin
                    seen_fall = 1;
                    chk("full_hsync_fall_h", f_h, 657);
                end
                if (f_v == 10'd1 && !seen_line) begin
                    seen_line = 1;
                    chk("full_line_clks", k, 3200);
                end
                if (n == 800) chk("full_hsync_width", low_ticks, 96);
            end
        end
        chk("full_tick_count", n, FULL_CLKS / 4);
        full_done = 1'b1;
    end

    initial begin
        int off_left;
        int guard;
        s_rst_n = 1'b0; s_en = 1'b0; s_col = 12'h000;
        f_rst_n = 1'b0; f_en = 1'b0; f_col = 12'hF3A;
        #23;
        check_reset_outputs("init");
        chk("init_active", s_act, 1);
        @(negedge clk);
        s_rst_n = 1'b1;
        f_rst_n = 1'b1;
        f_en    = 1'b1;

        // Constant colour over two frames and a bit
        repeat (2 * S_HT * S_VT * CLK_DIV + 20) drive_cycle(1'b1, 12'hF3A);

        // Freeze mid-picture for 37 clocks, then resume
        run_to(5, 3, "reach_freeze");
        repeat (37) drive_cycle(1'b0, 12'($urandom));
        repeat (40) drive_cycle(1'b1, 12'($urandom));

        // Random colour with random enable dropouts
        off_left = 0;
        repeat (1500) begin
            if (off_left == 0 && $urandom_range(63) == 0) off_left = $urandom_range(40, 1);
            if (off_left > 0) begin
                drive_cycle(1'b0, 12'($urandom));
                off_left--;
            end else begin
                drive_cycle(1'b1, 12'($urandom));
            end
        end

        // Asynchronous reset during horizontal front porch
        run_to(S_HP + S_HFP - 1, 1, "reach_reset");
        @(negedge clk);
        chk("pre_reset_h", s_h, S_HP + S_HFP - 1);
        #2;
        s_rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        s_en  = 1'b0;
        m_run = 0;
        m_pos = 0;
        @(negedge clk);
        s_rst_n = 1'b1;

        guard = 0;
        while (!full_done && guard < 20000) begin
            drive_cycle(1'b1, 12'($urandom));
            guard++;
        end
        if (!full_done) begin
            errors++;
            checks++;
            $display("FAIL full_timeout: full-geometry checker did not complete");
        end
        @(negedge clk);
        chk("queue_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
